// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the calculator accumulator ALU.
//   - OP_*  : 4-bit operation codes driven on alu.opCode
//   - ERR_* : 2-bit status codes reported on alu.errorCode
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_CLR  = 4'b1100;
  localparam logic [3:0] OP_LOAD = 4'b1101;
  localparam logic [3:0] OP_RSVD = 4'b1110;
  localparam logic [3:0] OP_POW  = 4'b1111;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

endpackage

// File: rtl/alu_pow.sv
// alu_pow: combinational unsigned power base**exponent, square-and-multiply
// over EXPW exponent bits (LSB first). Intermediates are WIDTH bits; each
// product is formed at 2*WIDTH so any carry past WIDTH is seen.
//   base     in  WIDTH  value raised to the power
//   exponent in  EXPW   power (0 gives 1, including 0**0)
//   powVal   out WIDTH  low WIDTH bits of the exact result
//   powOvf   out 1      exact result does not fit in WIDTH bits
module alu_pow #(
  parameter int WIDTH = 32,
  parameter int EXPW  = 5
) (
  input  logic [WIDTH-1:0] base,
  input  logic [EXPW-1:0]  exponent,
  output logic [WIDTH-1:0] powVal,
  output logic             powOvf
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0]   res, sqBase;
  logic [2*WIDTH-1:0] prod, sq;
  logic               ovf, baseOvf;

  always_comb begin
    res     = WIDTH'(1);
    sqBase  = base;
    prod    = '0;
    sq      = '0;
    ovf     = 1'b0;
    baseOvf = 1'b0;
    for (int i = 0; i < EXPW; i++) begin
      if (exponent[i]) begin
        prod = {ZERO, res} * {ZERO, sqBase};
        // A base that already overflowed is nonzero, so folding it in
        // always overflows the exact result too.
        if (baseOvf || (|prod[2*WIDTH-1:WIDTH])) ovf = 1'b1;
        res = prod[WIDTH-1:0];
      end
      sq = {ZERO, sqBase} * {ZERO, sqBase};
      if (|sq[2*WIDTH-1:WIDTH]) baseOvf = 1'b1;
      sqBase = sq[WIDTH-1:0];
    end
    powVal = res;
    powOvf = ovf;
  end

endmodule

// File: rtl/alu.sv
// alu: registered unsigned accumulator ALU. Each rising clk applies opCode to
// the accumulator A and/or operands P/Q; the new A appears on outALU at that
// edge and errorCode reports the status of that single operation.
//   clk       in  1      rising-edge clock
//   rst_n     in  1      synchronous active-low reset (clears A and errorCode)
//   inputP    in  WIDTH  operand P
//   inputQ    in  WIDTH  operand Q (low EXPW bits are the POW exponent)
//   opCode    in  4      operation select (see alu_pkg OP_*)
//   outALU    out WIDTH  accumulator
//   errorCode out 2      ERR_OK / ERR_DIV0 / ERR_OVF
// Build option: ALU_SATURATE_EN -- overflowing results saturate (all ones,
// or zero for SUB) instead of wrapping; errorCode still reports overflow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXPW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inputP,
  input  logic [WIDTH-1:0] inputQ,
  input  logic [3:0]       opCode,
  output logic [WIDTH-1:0] outALU,
  output logic [1:0]       errorCode
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   nextAcc;
  logic [1:0]         nextErr;
  logic               ovf;

  logic [WIDTH:0]     addFull;
  logic [2*WIDTH-1:0] mulFull;
  logic [2*WIDTH-1:0] shlFull;
  logic [SHW-1:0]     shAmt;
  logic               pIsZero;
  logic [WIDTH-1:0]   powVal;
  logic               powOvf;
  logic               unusedQHi;

  assign unusedQHi = ^inputQ[WIDTH-1:EXPW];

  assign shAmt   = inputP[SHW-1:0];
  assign pIsZero = (inputP == ZERO);
  assign addFull = {1'b0, acc} + {1'b0, inputP};
  assign mulFull = {ZERO, acc} * {ZERO, inputP};
  // Any 1 that lands in the upper half was shifted out of the accumulator.
  assign shlFull = {ZERO, acc} << shAmt;

  alu_pow #(.WIDTH(WIDTH), .EXPW(EXPW)) uPow (
    .base    (inputP),
    .exponent(inputQ[EXPW-1:0]),
    .powVal  (powVal),
    .powOvf  (powOvf)
  );

  always_comb begin
    nextAcc = acc;
    nextErr = ERR_OK;
    ovf     = 1'b0;
    case (opCode)
      OP_ADD: begin nextAcc = addFull[WIDTH-1:0]; ovf = addFull[WIDTH]; end
      OP_MUL: begin nextAcc = mulFull[WIDTH-1:0]; ovf = |mulFull[2*WIDTH-1:WIDTH]; end
      OP_DIV: begin
        if (pIsZero) nextErr = ERR_DIV0;
        else         nextAcc = acc / inputP;
      end
      OP_MOD: begin
        if (pIsZero) nextErr = ERR_DIV0;
        else         nextAcc = acc % inputP;
      end
      OP_SUB: begin nextAcc = acc - inputP; ovf = (inputP > acc); end
      OP_AND:  nextAcc = acc & inputP;
      OP_OR:   nextAcc = acc | inputP;
      OP_XOR:  nextAcc = acc ^ inputP;
      OP_NOT:  nextAcc = ~acc;
      OP_SHL: begin nextAcc = shlFull[WIDTH-1:0]; ovf = |shlFull[2*WIDTH-1:WIDTH]; end
      OP_SHR:  nextAcc = acc >> shAmt;
      OP_CLR:  nextAcc = ZERO;
      OP_LOAD: nextAcc = inputP;
      OP_POW: begin nextAcc = powVal; ovf = powOvf; end
      default: ;  // NOP and the reserved code hold A
    endcase
    if (ovf) begin
      nextErr = ERR_OVF;
`ifdef ALU_SATURATE_EN
      nextAcc = (opCode == OP_SUB) ? ZERO : '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= ZERO;
      errorCode <= ERR_OK;
    end else begin
      acc       <= nextAcc;
      errorCode <= nextErr;
    end
  end

  assign outALU = acc;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] inputP, inputQ;
  logic [3:0]       opCode;
  logic [WIDTH-1:0] outALU;
  logic [1:0]       errorCode;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  alu #(.WIDTH(WIDTH), .EXPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .inputP(inputP), .inputQ(inputQ),
    .opCode(opCode), .outALU(outALU), .errorCode(errorCode)
  );

  always #5 clk = ~clk;

  // Drive one operation, clock it, sample 1ns after the edge.
  task automatic doOp(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q);
    opCode = op; inputP = p; inputQ = q;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    doOp(OP_LOAD, 32'hDEAD_BEEF, 0);
    checks++;
    if (outALU !== 32'd0 || errorCode !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got=%h/%b want=00000000/00", outALU, errorCode);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sphere;
    logic [31:0] exp [5] = '{32'd0, 32'd1728, 32'd5427648, 32'd21710592, 32'd7236};
    logic [3:0]  ops [5] = '{OP_CLR, OP_POW, OP_MUL, OP_MUL, OP_DIV};
    logic [31:0] ps  [5] = '{32'd0, 32'd12, 32'd3141, 32'd4, 32'd3000};
    logic [31:0] qs  [5] = '{32'd0, 32'd3, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      doOp(ops[i], ps[i], qs[i]);
      checks++;
      if (outALU !== exp[i] || errorCode !== 2'b00) begin
        failures++;
        $display("FAIL sphere_step%0d got=%0d/%b want=%0d/00", i, outALU, errorCode, exp[i]);
      end
    end
  endtask

  task automatic test_div0;
    doOp(OP_LOAD, 32'd100, 0);
    doOp(OP_DIV, 32'd0, 0);
    checks++;
    if (outALU !== 32'd100 || errorCode !== 2'b01) begin
      failures++; $display("FAIL div0 got=%0d/%b want=100/01", outALU, errorCode);
    end
    doOp(OP_NOP, 32'd7, 0);
    checks++;
    if (outALU !== 32'd100 || errorCode !== 2'b00) begin
      failures++; $display("FAIL nop_after_div0 got=%0d/%b want=100/00", outALU, errorCode);
    end
    doOp(OP_MOD, 32'd0, 0);
    checks++;
    if (outALU !== 32'd100 || errorCode !== 2'b01) begin
      failures++; $display("FAIL mod0 got=%0d/%b want=100/01", outALU, errorCode);
    end
    doOp(OP_RSVD, 32'd9, 0);
    checks++;
    if (outALU !== 32'd100 || errorCode !== 2'b00) begin
      failures++; $display("FAIL reserved_op got=%0d/%b want=100/00", outALU, errorCode);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] want;
    doOp(OP_LOAD, 32'hFFFF_FFFF, 0);
    doOp(OP_ADD, 32'd1, 0);
    want = SAT ? 32'hFFFF_FFFF : 32'h0;
    checks++;
    if (outALU !== want || errorCode !== 2'b10) begin
      failures++; $display("FAIL add_ovf got=%h/%b want=%h/10", outALU, errorCode, want);
    end
    doOp(OP_CLR, 0, 0);
    checks++;
    if (outALU !== 32'd0 || errorCode !== 2'b00) begin
      failures++; $display("FAIL clr_after_ovf got=%h/%b want=00000000/00", outALU, errorCode);
    end
    doOp(OP_LOAD, 32'd5, 0);
    doOp(OP_SUB, 32'd7, 0);
    want = SAT ? 32'h0 : 32'hFFFF_FFFE;
    checks++;
    if (outALU !== want || errorCode !== 2'b10) begin
      failures++; $display("FAIL sub_borrow got=%h/%b want=%h/10", outALU, errorCode, want);
    end
    doOp(OP_POW, 32'd2, 32'd31);
    checks++;
    if (outALU !== 32'h8000_0000 || errorCode !== 2'b00) begin
      failures++; $display("FAIL pow_2_31 got=%h/%b want=80000000/00", outALU, errorCode);
    end
    doOp(OP_POW, 32'd3, 32'd21);
    want = SAT ? 32'hFFFF_FFFF : 32'h6F7C_52B3;
    checks++;
    if (outALU !== want || errorCode !== 2'b10) begin
      failures++; $display("FAIL pow_3_21 got=%h/%b want=%h/10", outALU, errorCode, want);
    end
    doOp(OP_LOAD, 32'h0001_0000, 0);
    doOp(OP_MUL, 32'h0001_0000, 0);
    want = SAT ? 32'hFFFF_FFFF : 32'h0;
    checks++;
    if (outALU !== want || errorCode !== 2'b10) begin
      failures++; $display("FAIL mul_ovf got=%h/%b want=%h/10", outALU, errorCode, want);
    end
    doOp(OP_LOAD, 32'h8000_0001, 0);
    doOp(OP_SHL, 32'd1, 0);
    want = SAT ? 32'hFFFF_FFFF : 32'h0000_0002;
    checks++;
    if (outALU !== want || errorCode !== 2'b10) begin
      failures++; $display("FAIL shl_ovf got=%h/%b want=%h/10", outALU, errorCode, want);
    end
    doOp(OP_LOAD, 32'h4000_0000, 0);
    doOp(OP_SHL, 32'd1, 0);
    checks++;
    if (outALU !== 32'h8000_0000 || errorCode !== 2'b00) begin
      failures++; $display("FAIL shl_no_ovf got=%h/%b want=80000000/00", outALU, errorCode);
    end
  endtask

  task automatic test_logic_shift;
    logic [3:0]  ops [8] = '{OP_POW, OP_SHL, OP_SHR, OP_LOAD, OP_MOD, OP_POW,
                             OP_LOAD, OP_AND};
    logic [31:0] ps  [8] = '{32'd0, 32'd4, 32'd4, 32'd17, 32'd5, 32'd0,
                             32'hF0F0_F0F0, 32'hFF00_FF00};
    logic [31:0] qs  [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0};
    logic [31:0] exp [8] = '{32'd1, 32'd16, 32'd1, 32'd17, 32'd2, 32'd0,
                             32'hF0F0_F0F0, 32'hF000_F000};
    for (int i = 0; i < 8; i++) begin
      doOp(ops[i], ps[i], qs[i]);
      checks++;
      if (outALU !== exp[i] || errorCode !== 2'b00) begin
        failures++;
        $display("FAIL logic_step%0d got=%h/%b want=%h/00", i, outALU, errorCode, exp[i]);
      end
    end
    doOp(OP_OR, 32'h0000_000F, 0);
    checks++;
    if (outALU !== 32'hF000_F00F) begin
      failures++; $display("FAIL or got=%h want=F000F00F", outALU);
    end
    doOp(OP_XOR, 32'hFFFF_FFFF, 0);
    checks++;
    if (outALU !== 32'h0FFF_0FF0) begin
      failures++; $display("FAIL xor got=%h want=0FFF0FF0", outALU);
    end
    doOp(OP_NOT, 32'h1234_5678, 0);
    checks++;
    if (outALU !== 32'hF000_F00F || errorCode !== 2'b00) begin
      failures++; $display("FAIL not got=%h/%b want=F000F00F/00", outALU, errorCode);
    end
  endtask

  task automatic test_reset_override;
    doOp(OP_LOAD, 32'h1234_5678, 0);
    doOp(OP_ADD, 32'hFFFF_FFFF, 0);   // leaves an overflow pending on errorCode
    rst_n = 1'b0;
    doOp(OP_ADD, 32'd1, 0);
    checks++;
    if (outALU !== 32'd0 || errorCode !== 2'b00) begin
      failures++; $display("FAIL reset_override got=%h/%b want=00000000/00", outALU, errorCode);
    end
    rst_n = 1'b1;
    doOp(OP_ADD, 32'd1, 0);
    checks++;
    if (outALU !== 32'd1 || errorCode !== 2'b00) begin
      failures++; $display("FAIL after_reset got=%h/%b want=00000001/00", outALU, errorCode);
    end
  endtask

  initial begin
    rst_n = 1'b0; opCode = OP_NOP; inputP = '0; inputQ = '0;
    @(negedge clk);
    test_reset;
    test_sphere;
    test_div0;
    test_overflow;
    test_logic_shift;
    test_reset_override;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
